ram_stream_reader: RTL

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader_pkg.sv | 14 +
 rtl/ram_rd_skid_buf.sv | 56 +++++
 rtl/ram_stream_reader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: FSM encoding and read-credit depth.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } state_e;

  // Words that may be in flight or buffered at once; matches the skid buffer depth.
  localparam int unsigned CreditDepth = 2;

endpackage

// File: rtl/ram_rd_skid_buf.sv
// Two-entry FIFO that holds RAM read data until the downstream stream accepts it.
module ram_rd_skid_buf #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] ent_q [2];
  logic [WIDTH-1:0] ent_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      ent_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      ent_q    <= ent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = ent_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a contiguous, wrapping RAM region out as valid/ready beats, issuing reads only
// while read credit remains so the two-entry buffer can never overflow.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Start,
  input  logic [AW-1:0]    i_Start_Addr,
  input  logic [AW:0]      i_Length,
  output logic [AW-1:0]    o_Read_Addr,
  output logic             o_Read_En,
  input  logic             i_Read_DV,
  input  logic [WIDTH-1:0] i_Read_Data,
  output logic             o_DV,
  output logic [WIDTH-1:0] o_Data,
  input  logic             i_Ready,
  output logic             o_Busy,
  output logic             o_Done
);

  localparam logic [2:0]    CreditLim = 3'(CreditDepth);
  localparam logic [AW+1:0] DepthW    = (AW+2)'(DEPTH);

  state_e        state_q, state_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] start_q, start_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   issued_q, issued_d;
  logic          inflight_q, inflight_d;

  logic          push, pop;
  logic [1:0]    buf_cnt;
  logic [2:0]    credit_used;
  logic [AW:0]   issued_inc;
  logic [AW+1:0] addr_sum;

  ram_rd_skid_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_L),
    .push_i (push),
    .data_i (i_Read_Data),
    .pop_i  (pop),
    .data_o (o_Data),
    .count_o(buf_cnt)
  );

  // Read data is only accepted in the cycle after a strobe; stray valids are dropped.
  assign push = i_Read_DV && inflight_q;
  assign o_DV = (buf_cnt != 2'd0);
  assign pop  = o_DV && i_Ready;

  // A word popped this cycle frees its credit immediately, which sustains one word per cycle.
  assign credit_used = {2'b00, inflight_q} + {1'b0, buf_cnt} - {2'b00, pop};
  assign issued_inc  = issued_q + {{AW{1'b0}}, 1'b1};

  always_comb begin
    addr_sum = {2'b00, start_q} + {1'b0, issued_q};
    if (addr_sum >= DepthW) begin
      addr_sum = addr_sum - DepthW;
    end
  end

  assign o_Read_Addr = addr_sum[AW-1:0];
  assign o_Read_En   = (state_q == StRead) && (issued_q < len_q) && (credit_used < CreditLim);
  assign o_Busy      = (state_q != StIdle);
  assign o_Done      = (state_q == StDone);

  always_comb begin
    state_d    = state_q;
    pend_d     = 1'b0;
    start_d    = start_q;
    len_d      = len_q;
    issued_d   = issued_q;
    inflight_d = o_Read_En;
    unique case (state_q)
      StIdle: begin
        // Requests are captured first and acted on the following cycle.
        if (pend_q) begin
          state_d = (len_q == '0) ? StDone : StRead;
        end else if (i_Start) begin
          pend_d   = 1'b1;
          start_d  = i_Start_Addr;
          len_d    = i_Length;
          issued_d = '0;
        end
      end
      StRead: begin
        if (o_Read_En) begin
          issued_d = issued_inc;
          if (issued_inc == len_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!inflight_q && ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && pop))) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= StIdle;
      pend_q     <= 1'b0;
      start_q    <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      start_q    <= start_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
    end
  end

endmodule
